sprite_anim_addr_gen: RTL
=========================

# sprite_anim_addr_gen

Parametrised sprite-animation VRAM address generator for the VGA path. It sits between the pixel counters and the sprite block-RAM sets. From the current pixel coordinates it produces a registered atlas address, a RAM-set select and an in-box flag. It advances through a configurable sprite sequence at a programmable frame rate, using loop, ping-pong, one-shot or hold playback.

## Interface
- CW, 7: pixel-coordinate and address-half width
- NUM_SPRITES, 8: sprites in the animation (1..64)
- PER_ATLAS, 6: sprites stored per block-RAM set
- COLS, 3: sprites per atlas row
- SPRITE_W, 42: sprite width in pixels
- SPRITE_H, 48: sprite height in pixels
- BOX_X, 42: left edge of the display box
- BOX_Y, 23: top edge of the display box
- HOLD, 6: VGA frames each sprite is shown (1..255)
- SELW, 1: select width; must cover ceil(NUM_SPRITES/PER_ATLAS) sets

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- frame_strobe  in  1  one-cycle pulse at each VGA frame start
- enable  in  1  animation runs when high; state frozen when low
- restart  in  1  one-cycle pulse: rewind animation
- mode  in  2  00 loop, 01 ping-pong, 10 one-shot, 11 hold
- mirror  in  1  horizontal flip (only under macro)
- hpixel  in  CW  current pixel column
- vpixel  in  CW  current pixel row
- address  out  2*CW  {row coordinate, column coordinate}, registered
- select  out  SELW  RAM-set index, registered
- in_box  out  1  pixel lies inside the display box, registered
- sprite_idx  out  6  current sprite number
- done  out  1  one-shot sequence finished

## Operation
- State: hold counter hc (8 bits), sprite index idx, direction dir (0 = up), done.
- Reset values: hc, idx, dir, done, address, select, in_box all 0.
- restart has priority over everything else, including enable low. It sets hc = 0, idx = 0, dir = 0 and done = 0.
- With enable = 1, each frame_strobe does one of two things:
  - If hc ≠ HOLD−1: hc increments.
  - Otherwise: hc = 0 and idx advances per mode, sampled at that strobe.
- Advance rules:
  - Loop: idx+1, wrapping N−1 → 0.
  - Ping-pong: move in direction dir. At N−1, dir becomes 1 and the next index is N−2. At 0, dir becomes 0 and the next index is 1. With N = 1, idx stays 0.
  - One-shot: idx+1 until N−1. At N−1, idx stays and done = 1 until restart.
  - Hold: idx unchanged.
- Offsets, derived from idx:
  - atlas = idx / PER_ATLAS, loc = idx % PER_ATLAS
  - H = (loc % COLS) · SPRITE_W, V = (loc / COLS) · SPRITE_H
  - select = atlas
- Per cycle, registered:
  - in_box = BOX_X ≤ hpixel < BOX_X+SPRITE_W and BOX_Y ≤ vpixel < BOX_Y+SPRITE_H
  - col = hpixel − BOX_X + H and row = vpixel − BOX_Y + V, both modulo 2^CW
  - address = in_box ? {row, col} : 0

## Timing
- address, select and in_box: 1-cycle latency from hpixel/vpixel.
- idx, sprite_idx and done update on the clock edge that samples the advancing frame_strobe. address reflects the new idx from the next cycle.
- Simultaneous restart and frame_strobe: restart wins and the strobe is lost.
- frame_strobe with enable = 0: ignored; hc is not counted.
- A mode change takes effect at the next advance. hc is not cleared by a mode change.
- Switching from one-shot to loop or ping-pong while done = 1: done clears on the next advance and the sequence continues from idx.
- Reset asserted mid-frame: outputs go to 0 immediately (asynchronous). Playback restarts at sprite 0 after release.

## Configuration
- SPRITE_ANIM_MIRROR_EN defined: when mirror = 1, col = (SPRITE_W−1) − (hpixel − BOX_X) + H, giving a horizontally flipped sprite. Latency is unchanged.
- Macro undefined: the mirror port is present but ignored, and col always uses the unflipped formula.

## Test plan
- Reset, then enable = 1, mode = 00, 6 strobes → idx 0→1; after 48 strobes total → idx wraps back to 0.
- Default parameters, idx = 4, hpixel = 42, vpixel = 23 → next cycle address = {48, 42}, select = 0, in_box = 1.
- idx = 7, hpixel = 50, vpixel = 30 → address = {7, 50}, select = 1. hpixel = 84 → in_box = 0 and address = 0.
- mode = 01, HOLD = 1 → idx sequence 0,1,…,7,6,…,0,1 with no repeated endpoints.
- mode = 10 → idx stops at 7 and done = 1. Restart pulsed together with a strobe → idx = 0, done = 0, hc = 0.
- With SPRITE_ANIM_MIRROR_EN defined: mirror = 1, idx = 0, hpixel = 42, vpixel = 23 → address = {0, 41}. Without the macro → address = {0, 0}.

Source files
------------

// File: rtl/sprite_anim_addr_gen.sv
// Sprite-animation VRAM address generator: steps through an atlas of sprites at a
// programmable frame rate and maps pixel coordinates to atlas addresses. Optional: SPRITE_ANIM_MIRROR_EN.
module sprite_anim_addr_gen #(
  parameter int CW          = 7,
  parameter int NUM_SPRITES = 8,
  parameter int PER_ATLAS   = 6,
  parameter int COLS        = 3,
  parameter int SPRITE_W    = 42,
  parameter int SPRITE_H    = 48,
  parameter int BOX_X       = 42,
  parameter int BOX_Y       = 23,
  parameter int HOLD        = 6,
  parameter int SELW        = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_strobe,
  input  logic              enable,
  input  logic              restart,
  input  logic [1:0]        mode,
  input  logic              mirror,
  input  logic [CW-1:0]     hpixel,
  input  logic [CW-1:0]     vpixel,
  output logic [2*CW-1:0]   address,
  output logic [SELW-1:0]   select,
  output logic              in_box,
  output logic [5:0]        sprite_idx,
  output logic              done
);

  typedef enum logic [1:0] {
    M_LOOP    = 2'b00,
    M_PING    = 2'b01,
    M_ONESHOT = 2'b10,
    M_HOLD    = 2'b11
  } mode_t;

  localparam logic [5:0]    LP_LAST  = 6'(NUM_SPRITES - 1);
  localparam logic [5:0]    LP_PEN   = 6'(NUM_SPRITES - 2);
  localparam logic [5:0]    LP_PER   = 6'(PER_ATLAS);
  localparam logic [5:0]    LP_COLS  = 6'(COLS);
  localparam logic [7:0]    LP_HLAST = 8'(HOLD - 1);
  localparam logic [CW-1:0] LP_BX    = CW'(BOX_X);
  localparam logic [CW-1:0] LP_BY    = CW'(BOX_Y);
  localparam logic [CW-1:0] LP_SW    = CW'(SPRITE_W);
  localparam logic [CW-1:0] LP_SH    = CW'(SPRITE_H);

  logic [7:0]      r_hc;
  logic [5:0]      r_idx;
  logic            r_dir;
  logic            r_done;
  logic [2*CW-1:0] r_addr;
  logic [SELW-1:0] r_sel;
  logic            r_in_box;

  logic [5:0]      w_atlas;
  logic [5:0]      w_loc;
  logic [CW-1:0]   w_h;
  logic [CW-1:0]   w_v;
  logic [CW-1:0]   w_dx;
  logic [CW-1:0]   w_dy;
  logic [CW-1:0]   w_col;
  logic [CW-1:0]   w_row;
  logic [31:0]     w_hx;
  logic [31:0]     w_vy;
  logic            w_in_box;
  mode_t           w_mode;

  assign w_mode  = mode_t'(mode);
  assign w_atlas = r_idx / LP_PER;
  assign w_loc   = r_idx % LP_PER;
  assign w_h     = CW'(w_loc % LP_COLS) * LP_SW;
  assign w_v     = CW'(w_loc / LP_COLS) * LP_SH;

  assign w_hx     = 32'(hpixel);
  assign w_vy     = 32'(vpixel);
  assign w_in_box = (w_hx >= 32'(BOX_X)) && (w_hx < 32'(BOX_X + SPRITE_W)) &&
                    (w_vy >= 32'(BOX_Y)) && (w_vy < 32'(BOX_Y + SPRITE_H));

  assign w_dx  = hpixel - LP_BX;
  assign w_dy  = vpixel - LP_BY;
  assign w_row = w_dy + w_v;

`ifdef SPRITE_ANIM_MIRROR_EN
  localparam logic [CW-1:0] LP_SWM1 = CW'(SPRITE_W - 1);
  assign w_col = mirror ? (LP_SWM1 - w_dx + w_h) : (w_dx + w_h);
`else
  // mirror stays on the port for drop-in compatibility; both arms are identical
  assign w_col = mirror ? (w_dx + w_h) : (w_dx + w_h);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hc     <= '0;
      r_idx    <= '0;
      r_dir    <= 1'b0;
      r_done   <= 1'b0;
      r_addr   <= '0;
      r_sel    <= '0;
      r_in_box <= 1'b0;
    end else begin
      r_in_box <= w_in_box;
      r_addr   <= w_in_box ? {w_row, w_col} : '0;
      r_sel    <= SELW'(w_atlas);

      if (restart) begin
        r_hc   <= '0;
        r_idx  <= '0;
        r_dir  <= 1'b0;
        r_done <= 1'b0;
      end else if (enable && frame_strobe) begin
        if (r_hc != LP_HLAST) begin
          r_hc <= r_hc + 8'd1;
        end else begin
          r_hc <= '0;
          case (w_mode)
            M_LOOP: begin
              r_done <= 1'b0;
              r_idx  <= (r_idx == LP_LAST) ? '0 : r_idx + 6'd1;
            end
            M_PING: begin
              r_done <= 1'b0;
              if (NUM_SPRITES > 1) begin
                // endpoints are visited once: turn around and step in the same advance
                if (!r_dir) begin
                  if (r_idx == LP_LAST) begin
                    r_dir <= 1'b1;
                    r_idx <= LP_PEN;
                  end else begin
                    r_idx <= r_idx + 6'd1;
                  end
                end else begin
                  if (r_idx == '0) begin
                    r_dir <= 1'b0;
                    r_idx <= 6'd1;
                  end else begin
                    r_idx <= r_idx - 6'd1;
                  end
                end
              end
            end
            M_ONESHOT: begin
              if (r_idx == LP_LAST) begin
                r_done <= 1'b1;
              end else begin
                r_idx <= r_idx + 6'd1;
              end
            end
            default: begin
              r_idx <= r_idx;
            end
          endcase
        end
      end
    end
  end

  assign address    = r_addr;
  assign select     = r_sel;
  assign in_box     = r_in_box;
  assign sprite_idx = r_idx;
  assign done       = r_done;

endmodule
